nn_neuron_mac: RTL and testbench

//  Single neuron compute unit. Consumes streamed (x, w) pairs in Q4.11 (fixed_t) with a per-neuron bias.

---
 rtl/nn_neuron_mac.sv | 187 ++++++++++++++++++
 tb/tb_nn_neuron_mac.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : nn_neuron_mac
// Purpose  : Single neuron compute unit. Streams (x, w) Q4.11 pairs, builds
//            bias + sum(x*w) in a 32-bit saturating accumulator, rescales the
//            result to Q4.11 and looks it up in an external sigmoid LUT.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start_i, num_inputs_i, bias_i, act_en_i - job set-up (in IDLE)
//            in_valid_i/in_ready_o, in_x_i, in_w_i   - operand stream
//            sig_rd_en_o, sig_addr_o, sig_data_i     - sigmoid LUT port
//            out_valid_o/out_ready_i, out_data_o, out_preact_o - result
//            busy_o              - neuron is not idle
// Revision : 1.0 - initial release
// ============================================================================
module nn_neuron_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 11,
  parameter int CNT_WIDTH  = 10,
  parameter int ACC_WIDTH  = 32,  // must be >= 2*DATA_WIDTH
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  num_inputs_i,
  input  logic [DATA_WIDTH-1:0] bias_i,
  input  logic                  act_en_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_x_i,
  input  logic [DATA_WIDTH-1:0] in_w_i,
  output logic                  sig_rd_en_o,
  output logic [ADDR_WIDTH-1:0] sig_addr_o,
  input  logic [DATA_WIDTH-1:0] sig_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [DATA_WIDTH-1:0] out_preact_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    N_IDLE      = 3'd0,
    N_LOAD_BIAS = 3'd1,
    N_MAC       = 3'd2,
    N_WAIT      = 3'd3,
    N_ACT0      = 3'd4,
    N_ACT1      = 3'd5,
    N_OUTPUT    = 3'd6
  } neuron_state_t;

  localparam logic signed [ACC_WIDTH-1:0]  c_ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  c_ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0]  c_Z_MAX    = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0]  c_Z_MIN    = ~c_Z_MAX;
  // LUT spans [-8.0, +8.0) of Q4.11 in 2^ADDR_WIDTH equal steps
  localparam logic signed [DATA_WIDTH-1:0] c_LUT_HIGH = DATA_WIDTH'(8 << FRAC_BITS);
  localparam logic signed [DATA_WIDTH-1:0] c_LUT_LOW  = -c_LUT_HIGH;
  localparam int                           c_ADDR_SHIFT = FRAC_BITS + 4 - ADDR_WIDTH;

  neuron_state_t                state_q;
  logic [CNT_WIDTH-1:0]         cnt_q, n_q, cnt_d;
  logic [DATA_WIDTH-1:0]        bias_q;
  logic                         act_en_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, prod_q, acc_d, acc_shr;
  logic                         prod_v_q;
  logic                         in_ready_q, sig_rd_en_q, out_valid_q;
  logic [ADDR_WIDTH-1:0]        sig_addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_preact_q, z_off;
  logic signed [DATA_WIDTH-1:0] z_d;
  logic signed [2*DATA_WIDTH-1:0] mul_d;

  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    // the two top bits disagree only on overflow; the top bit is the true sign
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) sat_add = s[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX;
    else                                sat_add = s[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    mul_d   = $signed(in_x_i) * $signed(in_w_i);
    cnt_d   = cnt_q + CNT_WIDTH'(1);
    acc_d   = prod_v_q ? sat_add(acc_q, prod_q) : acc_q;
    acc_shr = acc_d >>> FRAC_BITS;
    if (acc_shr > c_Z_MAX)      z_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (acc_shr < c_Z_MIN) z_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                        z_d = acc_shr[DATA_WIDTH-1:0];
    z_off  = z_d + c_LUT_HIGH;
    addr_d = '0;
    if (z_d < c_LUT_LOW)        addr_d = '0;
    else if (z_d >= c_LUT_HIGH) addr_d = '1;
    else                        addr_d = ADDR_WIDTH'(z_off >> c_ADDR_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= N_IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      bias_q       <= '0;
      act_en_q     <= 1'b0;
      acc_q        <= '0;
      prod_q       <= '0;
      prod_v_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      sig_rd_en_q  <= 1'b0;
      sig_addr_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_preact_q <= '0;
    end else begin
      case (state_q)
        N_IDLE: begin
          if (start_i) begin
            n_q      <= num_inputs_i;
            bias_q   <= bias_i;
            act_en_q <= act_en_i;
            state_q  <= N_LOAD_BIAS;
          end
        end
        N_LOAD_BIAS: begin
          acc_q    <= ACC_WIDTH'($signed(bias_q)) <<< FRAC_BITS;
          cnt_q    <= '0;
          prod_v_q <= 1'b0;
          state_q  <= (n_q == '0) ? N_WAIT : N_MAC;
        end
        N_MAC: begin
          // the product registered last cycle (if any) lands in acc now
          acc_q <= acc_d;
          if (in_valid_i && in_ready_q) begin
            prod_q   <= ACC_WIDTH'(mul_d);
            prod_v_q <= 1'b1;
            cnt_q    <= cnt_d;
            if (cnt_d == n_q) begin
              in_ready_q <= 1'b0;
              state_q    <= N_WAIT;
            end
          end else begin
            // in_ready is registered, so it rises one cycle into N_MAC
            prod_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        N_WAIT: begin
          // fold in the last product and launch the LUT read from the final
          // sum so z and the strobe are presented during the first activate cycle
          acc_q        <= acc_d;
          prod_v_q     <= 1'b0;
          out_preact_q <= z_d;
          sig_addr_q   <= addr_d;
          sig_rd_en_q  <= 1'b1;
          state_q      <= N_ACT0;
        end
        N_ACT0: begin
          sig_rd_en_q <= 1'b0;
          state_q     <= N_ACT1;
        end
        N_ACT1: begin
          out_data_q  <= act_en_q ? sig_data_i : out_preact_q;
          out_valid_q <= 1'b1;
          state_q     <= N_OUTPUT;
        end
        N_OUTPUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= N_IDLE;
          end
        end
        default: state_q <= N_IDLE;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign sig_rd_en_o  = sig_rd_en_q;
  assign sig_addr_o   = sig_addr_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_preact_o = out_preact_q;
  assign busy_o       = (state_q != N_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nn_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_neuron_mac
// Purpose  : Self-checking bench for nn_neuron_mac. Directed and random neuron
//            jobs are compared against an arithmetic reference model; the
//            sigmoid LUT is emulated with a one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_neuron_mac;

  localparam longint c_ACC_MAX = 64'sd2147483647;
  localparam longint c_ACC_MIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [9:0]  num_inputs_i;
  logic [15:0] bias_i;
  logic        act_en_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_x_i;
  logic [15:0] in_w_i;
  logic        sig_rd_en_o;
  logic [9:0]  sig_addr_o;
  logic [15:0] sig_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic [15:0] out_preact_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  nn_neuron_mac dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .num_inputs_i (num_inputs_i),
    .bias_i       (bias_i),
    .act_en_i     (act_en_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_x_i       (in_x_i),
    .in_w_i       (in_w_i),
    .sig_rd_en_o  (sig_rd_en_o),
    .sig_addr_o   (sig_addr_o),
    .sig_data_i   (sig_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_preact_o (out_preact_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // distinct content per address so a wrong address shows up in out_data
  function automatic logic [15:0] lut(input logic [9:0] a);
    logic [31:0] t;
    t = (32'(a) * 32'd40503) ^ 32'h00005A3C;
    return t[15:0];
  endfunction

  // LUT answers one cycle after the strobe; junk otherwise
  always @(posedge clk) sig_data_i <= sig_rd_en_o ? lut(sig_addr_o) : 16'($urandom);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " in_ready"},   64'(in_ready_o),   64'd0);
    chk({tag, " out_valid"},  64'(out_valid_o),  64'd0);
    chk({tag, " sig_rd_en"},  64'(sig_rd_en_o),  64'd0);
    chk({tag, " sig_addr"},   64'(sig_addr_o),   64'd0);
    chk({tag, " busy"},       64'(busy_o),       64'd0);
    chk({tag, " out_data"},   64'(out_data_o),   64'd0);
    chk({tag, " out_preact"}, 64'(out_preact_o), 64'd0);
  endtask

  // One complete neuron job. Operands are (fx,fw) repeated, or random when rnd.
  task automatic run_neuron(input int n, input logic [15:0] b, input logic act,
                            input bit gaps, input int ostall, input bit rnd,
                            input bit poke_start, input logic [15:0] fx,
                            input logic [15:0] fw, input string tag);
    logic [15:0] xs[$];
    logic [15:0] ws[$];
    longint acc, z;
    logic [9:0]  exp_addr;
    logic [15:0] exp_pre, exp_out;
    int cyc, idx, rd_pulses, ready_seen, exp_lat;
    bit will_accept, stable;

    for (int i = 0; i < n; i++) begin
      xs.push_back(rnd ? 16'($urandom) : fx);
      ws.push_back(rnd ? 16'($urandom) : fw);
    end

    // reference: Q4.11 arithmetic with clamping after every addition
    acc = longint'($signed(b)) * 2048;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'($signed(xs[i])) * longint'($signed(ws[i]));
      if (acc > c_ACC_MAX) acc = c_ACC_MAX;
      if (acc < c_ACC_MIN) acc = c_ACC_MIN;
    end
    z = acc >>> 11;
    if (z > 32767)  z = 32767;
    if (z < -32768) z = -32768;
    exp_pre = 16'(z);
    if (z < -16384)      exp_addr = 10'd0;
    else if (z >= 16384) exp_addr = 10'd1023;
    else                 exp_addr = 10'((z + 16384) / 32);
    exp_out = act ? lut(exp_addr) : exp_pre;

    @(negedge clk);
    start_i = 1'b1; num_inputs_i = 10'(n); bias_i = b; act_en_i = act;
    out_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0; idx = 0; rd_pulses = 0; ready_seen = 0;
    while (!out_valid_o && cyc < 3000) begin
      if (in_ready_o) ready_seen++;
      if (sig_rd_en_o) begin
        rd_pulses++;
        chk({tag, " sig_addr"}, 64'(sig_addr_o), 64'(exp_addr));
      end
      if (poke_start && cyc == 3) begin
        start_i = 1'b1; num_inputs_i = 10'd1; bias_i = 16'h7000;
      end else begin
        start_i = 1'b0; num_inputs_i = 10'(n); bias_i = b;
      end
      in_valid_i = (gaps && (cyc % 2 == 0)) ? 1'b0 : 1'b1;
      if (idx < n) begin
        in_x_i = xs[idx]; in_w_i = ws[idx];
      end else begin
        in_x_i = 16'($urandom); in_w_i = 16'($urandom);
      end
      will_accept = in_valid_i && in_ready_o;
      @(posedge clk);
      cyc++;
      if (will_accept) idx++;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;

    chk({tag, " out_valid reached"}, 64'(out_valid_o), 64'd1);
    if (!gaps) begin
      exp_lat = (n == 0) ? 4 : n + 5;
      chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    end
    chk({tag, " pairs consumed"}, 64'(idx), 64'(n));
    if (n == 0) chk({tag, " in_ready never high"}, 64'(ready_seen), 64'd0);
    chk({tag, " rd pulses"},  64'(rd_pulses),    64'd1);
    chk({tag, " out_preact"}, 64'(out_preact_o), 64'(exp_pre));
    chk({tag, " out_data"},   64'(out_data_o),   64'(exp_out));
    chk({tag, " busy"},       64'(busy_o),       64'd1);

    if (ostall > 0) begin
      stable = 1'b1;
      repeat (ostall) begin
        @(posedge clk);
        @(negedge clk);
        if (!(out_valid_o === 1'b1 && out_data_o === exp_out && out_preact_o === exp_pre))
          stable = 1'b0;
      end
      chk({tag, " stable while stalled"}, 64'(stable), 64'd1);
    end

    out_ready_i = 1'b1;
    start_i     = poke_start;
    @(posedge clk);
    @(negedge clk);
    out_ready_i = 1'b0;
    start_i     = 1'b0;
    chk({tag, " out_valid after handshake"}, 64'(out_valid_o), 64'd0);
    chk({tag, " idle after handshake"},      64'(busy_o),      64'd0);
  endtask

  initial begin
    int k, guard;
    rst = 1'b1; start_i = 1'b0; num_inputs_i = '0; bias_i = '0; act_en_i = 1'b0;
    in_valid_i = 1'b0; in_x_i = '0; in_w_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // T1: 0.5 + 2*(1.0*0.25) = 1.0
    run_neuron(2, 16'h0400, 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h0800, 16'h0200, "T1");
    chk("T1 preact const", 64'(out_preact_o), 64'h0800);

    // T2: positive saturation of the accumulator
    run_neuron(4, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF, "T2");
    chk("T2 preact const", 64'(out_preact_o), 64'h7FFF);

    // T3: no operands, most negative bias
    run_neuron(0, 16'h8000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, "T3");

    // T4: T1 with input gaps and output back-pressure
    run_neuron(2, 16'h0400, 1'b1, 1'b1, 5, 1'b0, 1'b0, 16'h0800, 16'h0200, "T4");

    // T5: reset after 3 of 8 pairs, then a clean bypass job
    @(negedge clk);
    start_i = 1'b1; num_inputs_i = 10'd8; bias_i = 16'h1234; act_en_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; in_valid_i = 1'b1; in_x_i = 16'h0700; in_w_i = 16'h0900;
    k = 0; guard = 0;
    while (k < 3 && guard < 20) begin
      if (in_ready_o) k++;
      @(negedge clk);
      guard++;
    end
    chk("T5 three pairs accepted", 64'(k), 64'd3);
    in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("T5 mid reset");
    run_neuron(1, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 16'h0800, 16'h0800, "T5");

    // T6: start pulses during N_MAC and during the output handshake
    run_neuron(3, 16'($urandom), 1'b1, 1'b0, 2, 1'b1, 1'b1, 16'h0, 16'h0, "T6");

    // negative saturation
    run_neuron(3, 16'h8000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 16'h8000, 16'h7FFF, "NEGSAT");

    // random jobs
    for (int r = 0; r < 6; r++)
      run_neuron(int'($urandom_range(1, 20)), 16'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b0,
                 16'h0, 16'h0, "RAND");

    // largest layer
    run_neuron(784, 16'($urandom), 1'b1, 1'b0, 0, 1'b1, 1'b0, 16'h0, 16'h0, "N784");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
